asmd_booth_multiplier: RTL and testbench
========================================

ASMD_BOOTH_MULTIPLIER -- requirements
Module: asmd_booth_multiplier

Interface
REQ-001 SHALL have parameter word_length, default 4, operand width in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request; sampled only when ready=1.
REQ-005 SHALL have port signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; captured with start.
REQ-006 SHALL have port word0  input  word_length  multiplicand, captured with start.
REQ-007 SHALL have port word1  input  word_length  multiplier, captured with start.
REQ-008 SHALL have port product  output  2*word_length  registered result, held until the next completion.
REQ-009 SHALL have port ready  output  1  high only in state IDLE.
REQ-010 SHALL have port done  output  1  one-cycle pulse when product updates.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, DONE; encoding free.
REQ-012 SHALL, in IDLE with start=1 at edge k: capture operands and mode, extend each to word_length+1 bits (sign-extend if signed_mode, else zero-extend), clear the accumulator and Booth bit q(-1), load the step counter with word_length+1, and enter RUN.
REQ-013 SHALL, in RUN, perform one radix-2 Booth step per cycle: pair (q0,q(-1)) = 01 add multiplicand, 10 subtract multiplicand, 00/11 no-op; then arithmetic right shift of {acc, multiplier, q(-1)}; decrement the counter.
REQ-014 SHALL keep the accumulator word_length+2 bits wide so that no step overflows.
REQ-015 SHALL, at the edge that completes the final step (edge k+word_length+1), write the low 2*word_length bits of the exact result to product and enter DONE.
REQ-016 SHALL assert done for exactly the one cycle in DONE; next edge returns to IDLE (ready=1); total ready-low time word_length+2 cycles.
REQ-017 SHALL ignore start while ready=0; no re-capture, no abort, and no effect on the result.
REQ-018 SHALL ignore changes on word0, word1 and signed_mode after capture.
REQ-019 SHALL produce results bit-exact to the mathematical product in both modes for all operand values, including most-negative times most-negative.
REQ-020 SHALL leave product unchanged in IDLE and RUN; only the DONE-entry edge writes it.

Reset
REQ-021 SHALL, on reset=1 at any edge, enter IDLE, set product=0, ready=1, done=0, and clear the accumulator, counter and q(-1).
REQ-022 SHALL treat reset mid-RUN as an abort: no done pulse, product=0, and start is accepted on the first edge after reset deasserts.
REQ-023 SHALL give reset priority over start in the same cycle.

Configuration
REQ-024 SHALL honour macro ASMD_ZERO_BYPASS_EN.
REQ-025 SHALL, with ASMD_ZERO_BYPASS_EN defined, go from IDLE directly to DONE when start is accepted with word0==0 or word1==0, writing product=0; done is high in the cycle after edge k and ready returns at edge k+2.
REQ-026 SHALL, without the macro, process zero operands through the full word_length+1 RUN steps with identical timing to any other operands.

Verification
REQ-027 SHALL pass this case: word_length=4, unsigned, word0=15, word1=15, start at edge k -> done at cycle after edge k+5, product=8'hE1, ready high after edge k+6.
REQ-028 SHALL pass this case: signed, word0=4'h8 (-8), word1=4'h8 (-8) -> product=8'h40; word0=4'h8, word1=4'h7 -> product=8'hC8 (-56).
REQ-029 SHALL pass this case: start held high plus new operands (3,3) during RUN of 5*6 -> single done, product=8'h1E; the second request is taken only after ready=1.
REQ-030 SHALL pass this case: reset pulsed at the third RUN cycle of 9*9 -> no done, product=0, ready=1; then 2*3 -> product=8'h06.
REQ-031 SHALL pass this case: word1=0, word0=4'hB -> with ASMD_ZERO_BYPASS_EN, done one cycle after the start edge, product=0; without the macro, done after word_length+1 steps, product=0.
REQ-032 SHALL pass this case: word_length=8, randomised 1000 operand pairs in both modes, compared against a reference model -> zero mismatches.

Source files
------------

// File: rtl/asmd_booth_multiplier.sv
// Sequential radix-2 Booth multiplier (IDLE/RUN/DONE), one Booth step per cycle.
// Optional ASMD_ZERO_BYPASS_EN: a zero operand skips RUN and completes on the next cycle.
module asmd_booth_multiplier #(
  parameter int word_length = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       signed_mode,
  input  logic [word_length-1:0]     word0,
  input  logic [word_length-1:0]     word1,
  output logic [2*word_length-1:0]   product,
  output logic                       ready,
  output logic                       done,
  output logic [1:0]                 state_o
);

  localparam int W  = word_length;
  localparam int CW = $clog2(W + 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [W+1:0]     acc_q;
  logic [W:0]       mcand_q;
  logic [W:0]       mplier_q;
  logic             qm1_q;
  logic [CW-1:0]    cnt_q;
  logic [2*W-1:0]   product_q;
  logic             ready_q;
  logic             done_q;

  logic [W+1:0]     mcand_ext;
  logic [W+1:0]     sum_d;
  logic [W+1:0]     acc_d;
  logic [W:0]       mplier_d;
  logic [W:0]       word0_ext;
  logic [W:0]       word1_ext;
  logic             zero_op;

  // Handshake: start is sampled only on an edge where ready=1; done pulses for one
  // cycle at the same time product takes its new value.
  assign word0_ext = {signed_mode & word0[W-1], word0};
  assign word1_ext = {signed_mode & word1[W-1], word1};
  assign mcand_ext = {mcand_q[W], mcand_q};
  assign zero_op   = (word0 == '0) || (word1 == '0);

  always_comb begin
    sum_d = acc_q;
    case ({mplier_q[0], qm1_q})
      2'b01:   sum_d = acc_q + mcand_ext;
      2'b10:   sum_d = acc_q - mcand_ext;
      default: sum_d = acc_q;
    endcase
    // Arithmetic right shift of {acc, multiplier, q(-1)}.
    acc_d    = {sum_d[W+1], sum_d[W+1:1]};
    mplier_d = {sum_d[0], mplier_q[W:1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      qm1_q     <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            mcand_q  <= word0_ext;
            mplier_q <= word1_ext;
            acc_q    <= '0;
            qm1_q    <= 1'b0;
            cnt_q    <= CW'(W + 1);
            ready_q  <= 1'b0;
`ifdef ASMD_ZERO_BYPASS_EN
            if (zero_op) begin
              product_q <= '0;
              done_q    <= 1'b1;
              state_q   <= DONE;
            end else begin
              state_q   <= RUN;
            end
`else
            state_q  <= RUN;
`endif
          end
        end
        RUN: begin
          acc_q    <= acc_d;
          mplier_q <= mplier_d;
          qm1_q    <= mplier_q[0];
          cnt_q    <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            // Low 2W bits of the sign-extended {acc, multiplier} after the last shift.
            product_q <= {acc_d[W-2:0], mplier_d};
            done_q    <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifndef ASMD_ZERO_BYPASS_EN
  logic unused_zero;
  assign unused_zero = zero_op;
`endif

  assign product = product_q;
  assign ready   = ready_q;
  assign done    = done_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_asmd_booth_multiplier.sv
// Scoreboard bench: drivers push expected products, monitors pop them on each done pulse.
module tb_asmd_booth_multiplier;

  logic        clk = 1'b0;
  logic        reset;
  logic        start4, sm4, start8, sm8;
  logic [3:0]  a4, b4;
  logic [7:0]  a8, b8;
  logic [7:0]  p4;
  logic [15:0] p8;
  logic        rdy4, dn4, rdy8, dn8;
  logic [1:0]  st4, st8;

  int          total = 0;
  int          bad   = 0;
  logic [7:0]  exp_q4[$];
  logic [15:0] exp_q8[$];
  logic [7:0]  last_p4 = '0;

`ifdef ASMD_ZERO_BYPASS_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 6;
`endif

  always #5 clk = ~clk;

  asmd_booth_multiplier #(.word_length(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .signed_mode(sm4),
    .word0(a4), .word1(b4), .product(p4), .ready(rdy4), .done(dn4), .state_o(st4)
  );

  asmd_booth_multiplier #(.word_length(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .signed_mode(sm8),
    .word0(a8), .word1(b8), .product(p8), .ready(rdy8), .done(dn8), .state_o(st8)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitors: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : mon4
    logic [7:0] e;
    if (dn4 === 1'b1) begin
      total++;
      if (exp_q4.size() == 0) begin
        bad++;
        $display("FAIL done4_unexpected: got done with product %0h expected no done", p4);
      end else begin
        e = exp_q4.pop_front();
        last_p4 = e;
        if (p4 !== e) begin
          bad++;
          $display("FAIL product4: got %0h expected %0h", p4, e);
        end
      end
    end
  end

  always @(negedge clk) begin : mon8
    logic [15:0] e;
    if (dn8 === 1'b1) begin
      total++;
      if (exp_q8.size() == 0) begin
        bad++;
        $display("FAIL done8_unexpected: got done with product %0h expected no done", p8);
      end else begin
        e = exp_q8.pop_front();
        if (p8 !== e) begin
          bad++;
          $display("FAIL product8: got %0h expected %0h", p8, e);
        end
      end
    end
  end

  task automatic wait_done4(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (dn4 !== 1'b1 && n < 40);
    chk({name, "_done_seen"}, dn4, 1'b1);
  endtask

  task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic sm,
                        input logic [7:0] e, input int lat_exp, input string name);
    int  lat;
    bit  got;
    @(negedge clk);
    chk({name, "_ready_before"}, rdy4, 1'b1);
    a4 = a; b4 = b; sm4 = sm; start4 = 1'b1;
    exp_q4.push_back(e);
    @(posedge clk);
    #1;
    start4 = 1'b0;
    a4 = 4'($urandom_range(0, 15));
    b4 = 4'($urandom_range(0, 15));
    sm4 = ~sm;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 1 && lat_exp > 1) chk({name, "_hold"}, p4, last_p4);
      if (dn4 === 1'b1) got = 1'b1;
    end
    chk({name, "_latency"}, lat, lat_exp);
    @(negedge clk);
    chk({name, "_ready_after"}, rdy4, 1'b1);
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic sm);
    longint x, y, p;
    logic [63:0] pv;
    int n;
    x = sm ? longint'($signed(a)) : longint'(a);
    y = sm ? longint'($signed(b)) : longint'(b);
    p = x * y;
    pv = p;
    @(negedge clk);
    a8 = a; b8 = b; sm8 = sm; start8 = 1'b1;
    exp_q8.push_back(pv[15:0]);
    @(posedge clk);
    #1;
    start8 = 1'b0;
    a8 = 8'($urandom_range(0, 255));
    b8 = 8'($urandom_range(0, 255));
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (dn8 !== 1'b1 && n < 40);
    if (dn8 !== 1'b1) chk("done8_timeout", dn8, 1'b1);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    start4 = 1'b0; sm4 = 1'b0; a4 = '0; b4 = '0;
    start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_product", p4, 8'h00);
    chk("reset_ready", rdy4, 1'b1);
    chk("reset_done", dn4, 1'b0);

    issue4(4'hF, 4'hF, 1'b0, 8'hE1, 6, "u15x15");
    issue4(4'h8, 4'h8, 1'b1, 8'h40, 6, "s_m8xm8");
    issue4(4'h8, 4'h7, 1'b1, 8'hC8, 6, "s_m8x7");
    issue4(4'h8, 4'h8, 1'b0, 8'h40, 6, "u8x8");
    issue4(4'hF, 4'hF, 1'b1, 8'h01, 6, "s_m1xm1");
    issue4(4'hC, 4'hA, 1'b0, 8'h78, 6, "u12x10");
    issue4(4'h5, 4'hB, 1'b1, 8'hE7, 6, "s5xm5");
    issue4(4'hB, 4'h0, 1'b0, 8'h00, ZLAT, "zero_w1");
    issue4(4'h0, 4'h9, 1'b1, 8'h00, ZLAT, "zero_w0");
    issue4(4'h7, 4'h7, 1'b1, 8'h31, 6, "s7x7");

    // Start held high with new operands during RUN: one done, then 3*3 once ready.
    @(negedge clk);
    a4 = 4'd5; b4 = 4'd6; sm4 = 1'b0; start4 = 1'b1;
    exp_q4.push_back(8'h1E);
    exp_q4.push_back(8'h09);
    @(posedge clk);
    #1 a4 = 4'd3; b4 = 4'd3;
    wait_done4("held_first");
    @(negedge clk);
    chk("held_ready", rdy4, 1'b1);
    @(posedge clk);
    #1 start4 = 1'b0;
    wait_done4("held_second");
    @(negedge clk);

    // Reset during the third RUN cycle aborts 9*9 with no done pulse.
    @(negedge clk);
    a4 = 4'd9; b4 = 4'd9; sm4 = 1'b0; start4 = 1'b1;
    @(posedge clk);
    #1 start4 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_product", p4, 8'h00);
    chk("abort_ready", rdy4, 1'b1);
    chk("abort_done", dn4, 1'b0);
    last_p4 = 8'h00;
    issue4(4'd2, 4'd3, 1'b0, 8'h06, 6, "after_abort");

    issue8(8'h80, 8'h80, 1'b1);
    issue8(8'hFF, 8'hFF, 1'b0);
    issue8(8'h80, 8'h7F, 1'b1);
    for (int i = 0; i < 1000; i++) begin
      issue8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'(i % 2));
    end

    repeat (4) @(negedge clk);
    chk("exp_q4_empty", exp_q4.size(), 0);
    chk("exp_q8_empty", exp_q8.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
